// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem read at a time, feeding a DEPTH-entry fetch queue.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects instead of silently aligning them.
module instr_fetch_unit #(
    parameter int           n        = 32,
    parameter int           DEPTH    = 2,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_instr,
    output logic [n-1:0] out_pc,
    output logic         fetch_misaligned
);

    localparam int CW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t         r_state;
    logic [n-1:0]   r_fpc;
    logic           r_req;
    logic [n-1:0]   r_addr;
    logic [CW:0]    r_count;
    logic           r_valid;
    logic           r_mis;
    logic [n-1:0]   r_q_pc    [DEPTH];
    logic [n-1:0]   r_q_instr [DEPTH];

    logic           w_pop;
    logic           w_enq;
    logic [CW:0]    w_count_nxt;
    logic           w_room;
    logic [CW-1:0]  w_wr_idx;
    logic [n-1:0]   w_fpc_inc;
    logic [n-1:0]   w_rpc;
    logic           w_mis;

    always_comb begin
        w_pop       = r_valid && out_ready;
        w_enq       = (r_state == BUSY) && r_req && imem_ack;
        w_count_nxt = r_count + (CW+1)'(w_enq) - (CW+1)'(w_pop);
        // Count includes this cycle's enqueue, so a new request always has a slot waiting.
        w_room      = (w_count_nxt < (CW+1)'(DEPTH));
        w_wr_idx    = CW'(r_count - (CW+1)'(w_pop));
        w_fpc_inc   = r_fpc + n'(4);
`ifdef FETCH_ALIGN_CHECK_EN
        w_rpc       = redirect_pc;
        w_mis       = |redirect_pc[1:0];
`else
        w_rpc       = redirect_pc & ~(n'(3));
        w_mis       = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUSY;
            r_fpc   <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else if (redirect) begin
            r_count <= '0;
            r_valid <= 1'b0;
            r_fpc   <= w_rpc;
            r_mis   <= w_mis;
            if (!r_req || imem_ack) begin
                if (w_mis) begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end else begin
                    r_state <= BUSY;
                    r_req   <= 1'b1;
                    r_addr  <= w_rpc;
                end
            end else begin
                // Request still in flight: keep it on the bus and discard its data later.
                r_state <= DROP;
            end
        end else begin
            if (w_pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    r_q_pc[i]    <= r_q_pc[i+1];
                    r_q_instr[i] <= r_q_instr[i+1];
                end
            end
            if (w_enq) begin
                r_q_pc[w_wr_idx]    <= r_fpc;
                r_q_instr[w_wr_idx] <= imem_rdata;
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            case (r_state)
                IDLE: begin
                    if (!r_mis && w_room) begin
                        r_state <= BUSY;
                        r_req   <= 1'b1;
                        r_addr  <= r_fpc;
                    end
                end
                BUSY: begin
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_addr <= r_fpc;
                    end else if (imem_ack) begin
                        r_fpc <= w_fpc_inc;
                        if (w_room) begin
                            r_addr <= w_fpc_inc;
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        if (!r_mis && w_room) begin
                            r_state <= BUSY;
                            r_addr  <= r_fpc;
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req         = r_req;
    assign imem_addr        = r_addr;
    assign out_valid        = r_valid;
    assign out_pc           = r_q_pc[0];
    assign out_instr        = r_q_instr[0];
    assign fetch_misaligned = r_mis;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder and fetch-order model push expected
// {pc, instr} pairs; an independent monitor pops them whenever decode accepts a head entry.
module tb_instr_fetch_unit;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, redirect, imem_req, imem_ack, out_valid, out_ready, fetch_misaligned;
    logic [N-1:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.n(N), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t sb[$];

    // Stimulus knobs, applied by step() for the next clock edge
    int          k_ack_mode, k_rdy_mode;   // 0 random, 1 always, 2 never
    logic        k_rst, k_redir;
    logic [31:0] k_rpc;

    // Values seen by the DUT at the edge step() just crossed
    logic        s_rst, s_req, s_ack, s_redir;
    logic [31:0] s_rpc, s_addr;

    // Reference model: the address the next useful fetch must come from
    logic [31:0] m_next_pc;
    logic        m_halt, m_drop;
    logic [31:0] m_drop_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model();
        if (s_rst) begin
            sb.delete();
            m_next_pc = 32'h0;
            m_halt    = 1'b0;
            m_drop    = 1'b0;
            return;
        end
        if (s_req && !s_ack) begin
            chk("req_held", imem_req, 1);
            chk("addr_stable", imem_addr, s_addr);
        end
        if (s_req && s_ack && !s_redir) begin
            if (m_drop) begin
                chk("dropped_addr", s_addr, m_drop_addr);
                m_drop = 1'b0;
            end else if (m_halt) begin
                chk("no_fetch_while_misaligned", s_req, 0);
            end else begin
                chk("fetch_addr", s_addr, m_next_pc);
                sb.push_back({m_next_pc, mem_word(m_next_pc)});
                m_next_pc = m_next_pc + 32'd4;
            end
        end
        if (s_redir) begin
            sb.delete();
            chk("redirect_flush_valid", out_valid, 0);
            if (s_req && !s_ack) begin
                m_drop      = 1'b1;
                m_drop_addr = s_addr;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            m_halt    = |s_rpc[1:0];
            m_next_pc = s_rpc;
`else
            m_halt    = 1'b0;
            m_next_pc = s_rpc & ~32'h3;
`endif
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        rst         = k_rst;
        redirect    = k_redir;
        redirect_pc = k_rpc;
        case (k_ack_mode)
            0:       imem_ack = imem_req && ($urandom_range(3) != 0);
            1:       imem_ack = imem_req;
            default: imem_ack = 1'b0;
        endcase
        imem_rdata = mem_word(imem_addr);
        case (k_rdy_mode)
            0:       out_ready = ($urandom_range(1) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
        s_rst = rst; s_req = imem_req; s_ack = imem_ack;
        s_redir = redirect; s_rpc = redirect_pc; s_addr = imem_addr;
        k_redir = 1'b0;
        @(posedge clk);
        #1;
        model();
    endtask

    // Monitor: checks every head entry that decode accepts at the coming edge
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !redirect && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got pc %h instr %h, expected nothing", out_pc, out_instr);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                end
            end
        end
    end

    initial begin
        logic [31:0] old_addr;
        int          w;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        k_rst = 1'b1; k_redir = 1'b0; k_rpc = '0; k_ack_mode = 2; k_rdy_mode = 2;
        m_next_pc = '0; m_halt = 1'b0; m_drop = 1'b0; m_drop_addr = '0;

        repeat (3) step();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_mis", fetch_misaligned, 0);

        k_rst = 1'b0;
        step();
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 32'h0);

        // Streaming: one instruction per cycle
        k_ack_mode = 1; k_rdy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, 32'(i * 4));
        end

        // Decode stalled: queue fills and fetch stops
        k_rdy_mode = 2;
        repeat (5) step();
        chk("full_req_low", imem_req, 0);
        chk("full_valid", out_valid, 1);
        k_rdy_mode = 1;
        repeat (4) step();

        // Late ack with redirect during the wait
        k_ack_mode = 2;
        w = 0;
        while (!imem_req && w < 10) begin
            step();
            w++;
        end
        chk("late_req_seen", imem_req, 1);
        old_addr = imem_addr;
        k_redir = 1'b1; k_rpc = 32'h100;
        step();
        chk("drop_req_held", imem_req, 1);
        chk("drop_addr_held", imem_addr, old_addr);
        chk("drop_valid", out_valid, 0);
        repeat (2) step();
        chk("drop_addr_held2", imem_addr, old_addr);
        k_ack_mode = 1; k_rdy_mode = 2;
        step();
        chk("after_drop_req", imem_req, 1);
        chk("after_drop_addr", imem_addr, 32'h100);
        chk("after_drop_valid", out_valid, 0);
        step();
        chk("redir_first_valid", out_valid, 1);
        chk("redir_first_pc", out_pc, 32'h100);

        // Redirect coinciding with ack and pop
        k_ack_mode = 1; k_rdy_mode = 1;
        repeat (3) step();
        k_redir = 1'b1; k_rpc = 32'h40;
        step();
        chk("redir_ack_valid", out_valid, 0);
        chk("redir_ack_req", imem_req, 1);
        chk("redir_ack_addr", imem_addr, 32'h40);

        // Address wrap
        k_redir = 1'b1; k_rpc = 32'hFFFF_FFF8;
        step();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr2", imem_addr, 32'h0000_0000);

        // Misaligned redirect
        k_redir = 1'b1; k_rpc = 32'h102;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_flag", fetch_misaligned, 1);
        chk("mis_req", imem_req, 0);
        repeat (3) step();
        chk("mis_req_stays", imem_req, 0);
        chk("mis_flag_sticky", fetch_misaligned, 1);
        k_redir = 1'b1; k_rpc = 32'h200;
        step();
        chk("mis_clear", fetch_misaligned, 0);
        chk("mis_resume_req", imem_req, 1);
        chk("mis_resume_addr", imem_addr, 32'h200);
        step();
        chk("mis_resume_pc", out_pc, 32'h200);
`else
        chk("align_addr", imem_addr, 32'h100);
        chk("align_mis", fetch_misaligned, 0);
        step();
        chk("align_pc", out_pc, 32'h100);
`endif

        // Randomized traffic with redirects and one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                k_ack_mode = $urandom_range(1);
                k_rdy_mode = $urandom_range(2);
            end
            if ($urandom_range(24) == 0) begin
                k_redir = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                k_rpc = ($urandom_range(3) == 0) ? $urandom : ($urandom & ~32'h3);
`else
                k_rpc = $urandom;
`endif
            end
            if (i == 1500) begin
                k_rst = 1'b1;
                repeat (2) step();
                chk("midrun_rst_valid", out_valid, 0);
                chk("midrun_rst_req", imem_req, 0);
                k_rst = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
